// File: rtl/otter_fetch_if.sv
// otter_fetch_if: bundles the instruction-memory request/response bus, the
// redirect input from the branch/jump unit and the valid/ready link to decode.
//   master : the fetch stage (drives imem_req/imem_addr and instr_*)
//   slave  : the environment (memory, branch unit, decode)
interface otter_fetch_if;
  logic        imem_req;     // request valid to instruction memory
  logic [31:0] imem_addr;    // word-aligned request address
  logic        imem_gnt;     // memory accepts request this cycle
  logic        imem_rvalid;  // response word valid
  logic [31:0] imem_rdata;   // response instruction word
  logic        redirect;     // one-cycle pulse: restart at redirect_pc
  logic [31:0] redirect_pc;  // new PC, low two bits ignored
  logic        instr_valid;  // instrn/instr_pc hold a valid instruction
  logic        instr_ready;  // decode consumes the instruction
  logic [31:0] instrn;       // fetched instruction word
  logic [31:0] instr_pc;     // address of instrn

  modport master (
    output imem_req, imem_addr, instr_valid, instrn, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instrn, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/otter_fetch.sv
// otter_fetch: instruction fetch stage of the OTTER core.
// Holds the PC, issues one word request at a time to instruction memory
// (req/gnt, then rvalid), and hands each word plus its PC to decode over a
// valid/ready link. A redirect restarts fetch at redirect_pc and any response
// still in flight is discarded.
// Ports:
//   clk   : core clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : otter_fetch_if.master (imem_*, redirect*, instr_*)
module otter_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  otter_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = {RESET_VEC[31:2], 2'b00};

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        drop_reg, drop_next;
  logic        valid_reg, valid_next;
  logic [31:0] instrn_reg, instrn_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic [31:0] redirect_target;

  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      drop_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      instrn_reg   <= NOP;
      instr_pc_reg <= 32'h0000_0000;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      drop_reg     <= drop_next;
      valid_reg    <= valid_next;
      instrn_reg   <= instrn_next;
      instr_pc_reg <= instr_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    drop_next     = drop_reg;
    valid_next    = valid_reg;
    instrn_next   = instrn_reg;
    instr_pc_next = instr_pc_reg;

    case (state_reg)
      IDLE: begin
        if (bus.redirect) pc_next = redirect_target;
        state_next = REQ;
      end

      REQ: begin
        if (bus.redirect) pc_next = redirect_target;
        if (bus.imem_gnt) begin
          // A redirect in the grant cycle means the response now on its way
          // belongs to the old PC and must be thrown away.
          drop_next  = bus.redirect;
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (bus.redirect) begin
          pc_next   = redirect_target;
          drop_next = 1'b1;
        end
        if (bus.imem_rvalid) begin
          if (drop_reg || bus.redirect) begin
            drop_next  = 1'b0;
            state_next = REQ;
          end else begin
            instrn_next   = bus.imem_rdata;
            instr_pc_next = pc_reg;
            pc_next       = pc_reg + 32'd4;  // wraps modulo 2^32
            valid_next    = 1'b1;
            state_next    = HOLD;
          end
        end
      end

      HOLD: begin
        // Redirect takes priority: the held instruction is on the wrong path.
        if (bus.redirect) begin
          valid_next = 1'b0;
          pc_next    = redirect_target;
          state_next = REQ;
        end else if (bus.instr_ready) begin
          valid_next = 1'b0;
          state_next = REQ;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.imem_req    = (state_reg == REQ);
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.instrn      = instrn_reg;
  assign bus.instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_otter_fetch.sv
// tb_otter_fetch: randomized scoreboard bench for otter_fetch.
// A memory model answers granted requests after a random delay with a word
// derived from the address; a stimulus process drives ready/redirect and
// records the expected next PC; a monitor pops and checks on each handshake.
module tb_otter_fetch;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  otter_fetch_if bus();

  otter_fetch #(.RESET_VEC(RESET_VEC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_fire   = 0;

  // stimulus knobs
  int gnt_pct   = 100;
  int max_delay = 0;
  int ready_pct = 100;
  int redir_pct = 0;
  bit stim_en   = 1'b0;
  bit mem_pending = 1'b0;

  // expected PCs of upcoming delivered instructions
  logic [31:0] exp_q[$];

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({tag, "_instrn"}, bus.instrn, 32'h0000_0013);
    chk({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
    chk({tag, "_imem_req"}, {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_imem_addr"}, bus.imem_addr, RESET_VEC);
  endtask

  // Instruction memory: one outstanding request, response after 0..max_delay
  // extra cycles; spurious rvalid when nothing is outstanding.
  initial begin
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] pend_addr;
    int          delay;
    bit          resp_sent;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    pend_addr = 32'd0;
    delay     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_pending     = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        continue;
      end
      req_s  = bus.imem_req;
      addr_s = bus.imem_addr;
      if (req_s) begin
        chk("no_req_while_outstanding", {31'd0, mem_pending}, 32'd0);
        chk("addr_aligned", {30'd0, addr_s[1:0]}, 32'd0);
      end
      bus.imem_gnt = req_s ? ($urandom_range(99) < gnt_pct) : ($urandom_range(1) == 1);
      resp_sent = 1'b0;
      if (mem_pending && delay == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instr_of(pend_addr);
        resp_sent       = 1'b1;
      end else begin
        bus.imem_rvalid = !mem_pending && ($urandom_range(99) < 5);
        bus.imem_rdata  = $urandom;
        if (mem_pending) delay--;
      end
      @(posedge clk);
      if (!rst_n) continue;
      if (resp_sent) mem_pending = 1'b0;
      if (req_s && bus.imem_gnt) begin
        mem_pending = 1'b1;
        pend_addr   = addr_s;
        delay       = $urandom_range(max_delay);
      end
    end
  end

  // Stimulus: decode readiness and redirects; a redirect restarts the
  // expected instruction stream at the aligned target.
  initial begin
    logic [31:0] rpc;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    forever begin
      @(negedge clk);
      if (!stim_en) begin
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        continue;
      end
      bus.instr_ready = ($urandom_range(99) < ready_pct);
      bus.redirect    = ($urandom_range(99) < redir_pct);
      case ($urandom_range(3))
        0:       rpc = 32'hFFFF_FFFC | {30'd0, 2'($urandom_range(3))};
        1:       rpc = 32'h0000_0103;
        default: rpc = $urandom;
      endcase
      bus.redirect_pc = rpc;
      if (bus.redirect) begin
        exp_q.delete();
        exp_q.push_back({rpc[31:2], 2'b00});
      end
    end
  end

  // Monitor: checks delivered instructions against the expected stream and
  // that a presented instruction stays put until consumed or redirected.
  initial begin
    bit          have_prev;
    bit          prev_valid, prev_fire, prev_redir;
    logic [31:0] prev_instrn, prev_pc, exp_pc;
    bit          fire;
    int          idle;
    have_prev = 1'b0;
    idle = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        have_prev = 1'b0;
        idle = 0;
        continue;
      end
      if (have_prev && prev_valid) begin
        if (!prev_fire && !prev_redir) begin
          chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
          chk("hold_instrn", bus.instrn, prev_instrn);
          chk("hold_pc", bus.instr_pc, prev_pc);
          chk("hold_no_req", {31'd0, bus.imem_req}, 32'd0);
        end else begin
          chk("valid_drops", {31'd0, bus.instr_valid}, 32'd0);
        end
      end
      fire = bus.instr_valid && bus.instr_ready && !bus.redirect;
      if (fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h, expected none", bus.instr_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          chk("instr_pc", bus.instr_pc, exp_pc);
          chk("instrn", bus.instrn, instr_of(exp_pc));
          exp_q.push_back(exp_pc + 32'd4);
          $display("instr pc=%h word=%h", bus.instr_pc, bus.instrn);
        end
        n_fire++;
        idle = 0;
      end else begin
        idle++;
        if (idle > 400) begin
          chk("progress_timeout", 32'd0, 32'd1);
          idle = 0;
        end
      end
      have_prev   = 1'b1;
      prev_valid  = bus.instr_valid;
      prev_fire   = fire;
      prev_redir  = bus.redirect;
      prev_instrn = bus.instrn;
      prev_pc     = bus.instr_pc;
    end
  end

  task automatic run_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset at a negedge and check the single IDLE cycle leads to a
  // request at RESET_VEC.
  task automatic release_reset();
    exp_q.delete();
    exp_q.push_back(RESET_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, RESET_VEC);
    stim_en = 1'b1;
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    run_cycles(3);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // immediate grant, one-cycle response, always ready
    run_cycles(30);

    // decode stalls: instruction must be held, no new request
    ready_pct = 0;
    run_cycles(8);
    ready_pct = 100;
    run_cycles(10);

    // random traffic with redirects
    gnt_pct = 60; max_delay = 3; ready_pct = 60; redir_pct = 8;
    run_cycles(2500);

    // asynchronous reset while a response is outstanding
    for (int r = 0; r < 3; r++) begin
      redir_pct = 0;
      waited = 0;
      do begin
        @(posedge clk);
        #1;
        waited++;
      end while (!mem_pending && waited < 200);
      chk("wait_pending", {31'd0, mem_pending}, 32'd1);
      #2;
      rst_n   = 1'b0;
      stim_en = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      run_cycles(2);
      release_reset();
      redir_pct = 8;
      run_cycles(300);
    end

    // drain
    redir_pct = 0; ready_pct = 100;
    run_cycles(30);
    n_checks++;
    if (n_fire < 100) begin
      n_fail++;
      $display("FAIL throughput: got %0d instructions, expected at least 100", n_fire);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
